seg_scan_driver: RTL

Four-digit multiplexed seven-segment driver that consumes the fast scan tick and the blink tick produced by the clock divider. On each rising edge of `fastClk` it blanks all anodes for a programmable guard interval, then drives the next digit. Digit values are double-buffered and committed only at frame boundaries, so the display never tears. Digits selected by `blink_mask` flash at the `blinkClk` rate.

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the seven-segment scan driver.
//   master : divider ticks, digit data, load strobe and blink mask in; segment/anode view out
//   slave  : the driver itself
interface seg_scan_driver_if;
  logic        fastClk;
  logic        blinkClk;
  logic [15:0] digits_in;
  logic [3:0]  digit_en_in;
  logic        load;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        frame_start;

  modport master (
    output fastClk, blinkClk, digits_in, digit_en_in, load, blink_mask,
    input  seg, an, scan_idx, frame_start
  );

  modport slave (
    input  fastClk, blinkClk, digits_in, digit_en_in, load, blink_mask,
    output seg, an, scan_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anode guard blanking,
// frame-synchronous double-buffered digit data and per-digit blink.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of seg_scan_driver_if (ticks, data, load, blink in;
//          seg/an/scan_idx/frame_start out, all registered)
module seg_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIG_N  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned IDX_W  = 2;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [DIG_N-1:0] AN_OFF  = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t             state, stateNxt;
  logic               fastQ;
  logic               tick;
  logic [CNT_W-1:0]   guardCnt, guardCntNxt;
  logic [IDX_W-1:0]   scanIdx, scanIdxNxt;
  logic [DIG_N-1:0]   anQ, anNxt;
  logic [SEG_W-1:0]   segQ, segNxt;
  logic               frameStartQ, frameStartNxt;
  logic [DATA_W-1:0]  actDig, actDigNxt, pendDig, pendDigNxt;
  logic [DIG_N-1:0]   actEn, actEnNxt, pendEn, pendEnNxt;
  logic               pendingValid, pendingValidNxt;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [SEG_W-1:0] hexDecode(input logic [3:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Segment pattern for one digit, including enable and live blink blanking.
  function automatic logic [SEG_W-1:0] digitSeg(
    input logic [DATA_W-1:0] dig,
    input logic [DIG_N-1:0]  en,
    input logic [IDX_W-1:0]  idx,
    input logic [DIG_N-1:0]  mask,
    input logic              blink
  );
    logic [SEG_W-1:0] s;
    if (!en[idx] || (mask[idx] && blink)) s = SEG_OFF;
    else                                  s = hexDecode(dig[{idx, 2'b00} +: 4]);
    return s;
  endfunction

  assign tick = bus.fastClk & ~fastQ;

  // Next-state, buffer and output computation.
  always_comb begin
    stateNxt        = state;
    guardCntNxt     = guardCnt;
    scanIdxNxt      = scanIdx;
    anNxt           = anQ;
    segNxt          = segQ;
    frameStartNxt   = 1'b0;
    actDigNxt       = actDig;
    actEnNxt        = actEn;
    pendDigNxt      = pendDig;
    pendEnNxt       = pendEn;
    pendingValidNxt = pendingValid;

    if (bus.load) begin
      pendDigNxt      = bus.digits_in;
      pendEnNxt       = bus.digit_en_in;
      pendingValidNxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tick) begin
          stateNxt    = BLANK;
          anNxt       = AN_OFF;
          segNxt      = SEG_OFF;
          guardCntNxt = CNT_W'(BLANK_CYCLES - 1);
        end
      end

      BLANK: begin
        if (guardCnt == '0) begin
          stateNxt   = DRIVE;
          scanIdxNxt = scanIdx + IDX_W'(1);
          // Frame boundary: swap in new data; a same-cycle load bypasses pending.
          if (scanIdx == IDX_W'(DIG_N - 1)) begin
            frameStartNxt = 1'b1;
            if (bus.load) begin
              actDigNxt       = bus.digits_in;
              actEnNxt        = bus.digit_en_in;
              pendingValidNxt = 1'b0;
            end else if (pendingValid) begin
              actDigNxt       = pendDig;
              actEnNxt        = pendEn;
              pendingValidNxt = 1'b0;
            end
          end
          anNxt  = ~(DIG_N'(1) << scanIdxNxt);
          segNxt = digitSeg(actDigNxt, actEnNxt, scanIdxNxt, bus.blink_mask, bus.blinkClk);
        end else begin
          guardCntNxt = guardCnt - CNT_W'(1);
        end
      end

      DRIVE: begin
        if (tick) begin
          stateNxt    = BLANK;
          anNxt       = AN_OFF;
          segNxt      = SEG_OFF;
          guardCntNxt = CNT_W'(BLANK_CYCLES - 1);
        end else begin
          anNxt  = ~(DIG_N'(1) << scanIdx);
          segNxt = digitSeg(actDig, actEn, scanIdx, bus.blink_mask, bus.blinkClk);
        end
      end

      default: stateNxt = IDLE;
    endcase
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fastQ        <= 1'b0;
      guardCnt     <= '0;
      scanIdx      <= IDX_W'(DIG_N - 1);
      anQ          <= AN_OFF;
      segQ         <= SEG_OFF;
      frameStartQ  <= 1'b0;
      actDig       <= '0;
      actEn        <= '0;
      pendDig      <= '0;
      pendEn       <= '0;
      pendingValid <= 1'b0;
    end else begin
      state        <= stateNxt;
      fastQ        <= bus.fastClk;
      guardCnt     <= guardCntNxt;
      scanIdx      <= scanIdxNxt;
      anQ          <= anNxt;
      segQ         <= segNxt;
      frameStartQ  <= frameStartNxt;
      actDig       <= actDigNxt;
      actEn        <= actEnNxt;
      pendDig      <= pendDigNxt;
      pendEn       <= pendEnNxt;
      pendingValid <= pendingValidNxt;
    end
  end

  assign bus.seg         = segQ;
  assign bus.an          = anQ;
  assign bus.scan_idx    = scanIdx;
  assign bus.frame_start = frameStartQ;

endmodule
